// File: rtl/clock_monitor_pkg.sv
// Shared constants for the derived-clock phase monitor: FSM state encodings,
// fault cause codes and bit positions inside the 4-bit sample vector.
package clock_monitor_pkg;

  // FSM state encodings
  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StAcquire = 2'd1;
  localparam logic [1:0] StLocked  = 2'd2;
  localparam logic [1:0] StFault   = 2'd3;

  // Fault cause codes reported on fault_code
  localparam logic [2:0] FC_NONE          = 3'd0;
  localparam logic [2:0] FC_STALL         = 3'd1;
  localparam logic [2:0] FC_NO_LOCK       = 3'd2;
  localparam logic [2:0] FC_PAIR          = 3'd3;
  localparam logic [2:0] FC_MISSED_TOGGLE = 3'd4;

  // Sample vector layout: {processor, imem, dmem, regfile}
  localparam int unsigned BitProc    = 3;
  localparam int unsigned BitImem    = 2;
  localparam int unsigned BitDmem    = 1;
  localparam int unsigned BitRegfile = 0;

endpackage

// File: rtl/clock_phase_sampler.sv
// Samples the four derived clocks as data on the master clock and flags
// per-cycle toggling and complementary-pair health.
module clock_phase_sampler
  import clock_monitor_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] sample_i,
  output logic       toggle_ok_o,
  output logic       any_toggle_o,
  output logic       pair_ok_o
);

  logic [3:0] s_cur_q, s_cur_d;
  logic [3:0] s_prev_q, s_prev_d;
  logic       cur_valid_q, cur_valid_d;
  logic       prev_valid_q, prev_valid_d;
  logic [3:0] diff;

  // Next-state: shift the sample pipeline; s_prev only holds a real sample
  // from the second edge after reset release, hence the two-stage valid.
  always_comb begin
    s_cur_d      = sample_i;
    s_prev_d     = s_cur_q;
    cur_valid_d  = 1'b1;
    prev_valid_d = cur_valid_q;
  end

  // Sample registers
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      s_cur_q      <= 4'b0000;
      s_prev_q     <= 4'b0000;
      cur_valid_q  <= 1'b0;
      prev_valid_q <= 1'b0;
    end else begin
      s_cur_q      <= s_cur_d;
      s_prev_q     <= s_prev_d;
      cur_valid_q  <= cur_valid_d;
      prev_valid_q <= prev_valid_d;
    end
  end

  // Health flags derived from the two most recent samples
  always_comb begin
    diff         = s_cur_q ^ s_prev_q;
    toggle_ok_o  = prev_valid_q && (diff == 4'b1111);
    any_toggle_o = prev_valid_q && (diff != 4'b0000);
    pair_ok_o    = (s_cur_q[BitProc] ^ s_cur_q[BitDmem]) &&
                   (s_cur_q[BitImem] ^ s_cur_q[BitRegfile]);
  end

endmodule

// File: rtl/clock_phase_monitor.sv
// Monitors the clock divider outputs against the master clock: acquires lock
// after consecutive healthy samples, then faults on pair or toggle violations.
module clock_phase_monitor
  import clock_monitor_pkg::*;
#(
  parameter int unsigned LOCK_CYCLES = 8,
  parameter int unsigned TIMEOUT     = 64
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       processor_clock,
  input  logic       imem_clock,
  input  logic       dmem_clock,
  input  logic       regfile_clock,
  input  logic       clear,
  output logic       locked,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] fault_count
);

  localparam int unsigned WaitW = $clog2(TIMEOUT);
  localparam int unsigned GoodW = $clog2(LOCK_CYCLES + 1);
  localparam logic [WaitW-1:0] WaitLast = WaitW'(TIMEOUT - 1);
  localparam logic [GoodW-1:0] GoodLast = GoodW'(LOCK_CYCLES - 1);

  logic             toggle_ok, any_toggle, pair_ok, good_sample;
  logic [1:0]       state_q, state_d;
  logic [WaitW-1:0] wait_cnt_q, wait_cnt_d;
  logic [GoodW-1:0] good_cnt_q, good_cnt_d;
  logic [2:0]       fault_code_q, fault_code_d;
  logic [7:0]       fault_count_q, fault_count_d;
  logic             enter_fault;

  clock_phase_sampler u_sampler (
    .clk_i        (clock),
    .rst_ni       (reset),
    .sample_i     ({processor_clock, imem_clock, dmem_clock, regfile_clock}),
    .toggle_ok_o  (toggle_ok),
    .any_toggle_o (any_toggle),
    .pair_ok_o    (pair_ok)
  );

  assign good_sample = toggle_ok && pair_ok;

  // Next-state logic for the FSM, counters and fault bookkeeping
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    good_cnt_d    = good_cnt_q;
    fault_code_d  = fault_code_q;
    fault_count_d = fault_count_q;
    enter_fault   = 1'b0;
    case (state_q)
      StIdle: begin
        if (any_toggle) begin
          state_d    = StAcquire;
          wait_cnt_d = '0;
          good_cnt_d = '0;
        end else if (wait_cnt_q == WaitLast) begin
          state_d      = StFault;
          fault_code_d = FC_STALL;
          enter_fault  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
        end
      end
      StAcquire: begin
        // Lock is checked first so it wins over a simultaneous timeout
        if (good_sample && (good_cnt_q == GoodLast)) begin
          state_d    = StLocked;
          wait_cnt_d = '0;
          good_cnt_d = '0;
        end else if (wait_cnt_q == WaitLast) begin
          state_d      = StFault;
          fault_code_d = FC_NO_LOCK;
          enter_fault  = 1'b1;
        end else begin
          wait_cnt_d = wait_cnt_q + 1'b1;
          good_cnt_d = good_sample ? good_cnt_q + 1'b1 : '0;
        end
      end
      StLocked: begin
        if (!pair_ok) begin
          state_d      = StFault;
          fault_code_d = FC_PAIR;
          enter_fault  = 1'b1;
        end else if (!toggle_ok) begin
          state_d      = StFault;
          fault_code_d = FC_MISSED_TOGGLE;
          enter_fault  = 1'b1;
        end
      end
      StFault: begin
        if (clear) begin
          state_d      = StIdle;
          wait_cnt_d   = '0;
          good_cnt_d   = '0;
          fault_code_d = FC_NONE;
        end
      end
      default: state_d = StIdle;
    endcase
    if (enter_fault && (fault_count_q != 8'hFF)) begin
      fault_count_d = fault_count_q + 8'd1;
    end
  end

  // State and counter registers
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q       <= StIdle;
      wait_cnt_q    <= '0;
      good_cnt_q    <= '0;
      fault_code_q  <= FC_NONE;
      fault_count_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      good_cnt_q    <= good_cnt_d;
      fault_code_q  <= fault_code_d;
      fault_count_q <= fault_count_d;
    end
  end

  // Outputs are decodes of registered state
  always_comb begin
    locked      = (state_q == StLocked);
    fault       = (state_q == StFault);
    fault_code  = fault_code_q;
    fault_count = fault_count_q;
  end

endmodule

// File: tb/tb_clock_phase_monitor.sv
// Directed bench for clock_phase_monitor driven by a behavioural divider model.
module tb_clock_phase_monitor;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       clear = 1'b0;
  logic       div;
  logic       f_pair = 1'b0;    // dmem follows processor instead of inverting
  logic       f_freeze = 1'b0;  // imem/regfile hold last value (still complementary)
  logic       frz = 1'b0;
  logic       f_zero = 1'b0;    // all derived clocks stuck at 0
  logic       processor_clock, imem_clock, dmem_clock, regfile_clock;
  logic       locked, fault;
  logic [2:0] fault_code;
  logic [7:0] fault_count;

  int errors = 0;
  int checks = 0;
  int exp_cnt = 0;

  always #5 clock = ~clock;

  // Divider model: toggles on the master negedge, reset with the monitor
  always @(negedge clock or negedge reset) begin
    if (!reset) div <= 1'b0;
    else        div <= ~div;
  end

  assign processor_clock = f_zero ? 1'b0 : div;
  assign dmem_clock      = f_zero ? 1'b0 : (f_pair ? div : ~div);
  assign imem_clock      = f_zero ? 1'b0 : (f_freeze ? frz : div);
  assign regfile_clock   = f_zero ? 1'b0 : (f_freeze ? ~frz : ~div);

  clock_phase_monitor #(
    .LOCK_CYCLES (8),
    .TIMEOUT     (16)
  ) dut (
    .clock           (clock),
    .reset           (reset),
    .processor_clock (processor_clock),
    .imem_clock      (imem_clock),
    .dmem_clock      (dmem_clock),
    .regfile_clock   (regfile_clock),
    .clear           (clear),
    .locked          (locked),
    .fault           (fault),
    .fault_code      (fault_code),
    .fault_count     (fault_count)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Healthy inputs after reset release: locked must rise on edge 11 exactly
  task automatic relock_from_reset(input string tag);
    for (int k = 1; k <= 11; k++) begin
      tick();
      checks++;
      if (locked !== (k == 11) || fault !== 1'b0) begin
        errors++;
        $display("FAIL %s edge %0d: locked=%b fault=%b, want locked=%b fault=0",
                 tag, k, locked, fault, (k == 11));
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (3) tick();
    checks++;
    if ({locked, fault, fault_code, fault_count} !== 13'd0) begin
      errors++;
      $display("FAIL reset_state: locked=%b fault=%b code=%0d count=%0d, want all 0",
               locked, fault, fault_code, fault_count);
    end
    reset = 1'b1;
  endtask

  task automatic test_lock();
    relock_from_reset("lock");
  endtask

  task automatic test_pair_fault();
    @(negedge clock);
    f_pair = 1'b1;
    tick();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL pair_latency: locked=%b, want 1 on the sampling edge", locked);
    end
    @(negedge clock);
    f_pair = 1'b0;
    tick();
    exp_cnt++;
    checks++;
    if (locked !== 1'b0 || fault !== 1'b1 || fault_code !== 3'd3 || fault_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL pair_fault: locked=%b fault=%b code=%0d count=%0d, want 0 1 3 %0d",
               locked, fault, fault_code, fault_count, exp_cnt);
    end
    repeat (4) tick();
    checks++;
    if (fault !== 1'b1 || fault_code !== 3'd3) begin
      errors++;
      $display("FAIL pair_sticky: fault=%b code=%0d, want 1 3", fault, fault_code);
    end
  endtask

  task automatic test_clear_relock();
    @(negedge clock);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    checks++;
    if (fault !== 1'b0 || fault_code !== 3'd0 || locked !== 1'b0 || fault_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL clear_exit: fault=%b code=%0d locked=%b count=%0d, want 0 0 0 %0d",
               fault, fault_code, locked, fault_count, exp_cnt);
    end
    for (int k = 1; k <= 9; k++) begin
      tick();
      checks++;
      if (locked !== (k == 9) || fault !== 1'b0) begin
        errors++;
        $display("FAIL clear_relock edge %0d: locked=%b fault=%b, want %b 0",
                 k, locked, fault, (k == 9));
      end
    end
    // clear outside FAULT must have no effect
    @(negedge clock);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();
    checks++;
    if (locked !== 1'b1 || fault !== 1'b0) begin
      errors++;
      $display("FAIL clear_ignored: locked=%b fault=%b, want 1 0", locked, fault);
    end
  endtask

  task automatic test_missed_toggle();
    @(negedge clock);
    frz = div;
    f_freeze = 1'b1;
    tick();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL missed_latency: locked=%b, want 1 on the sampling edge", locked);
    end
    @(negedge clock);
    f_freeze = 1'b0;
    tick();
    exp_cnt++;
    checks++;
    if (fault !== 1'b1 || locked !== 1'b0 || fault_code !== 3'd4 || fault_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL missed_toggle: fault=%b locked=%b code=%0d count=%0d, want 1 0 4 %0d",
               fault, locked, fault_code, fault_count, exp_cnt);
    end
  endtask

  task automatic test_no_lock();
    @(negedge clock);
    f_pair = 1'b1;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    tick();  // IDLE sees the toggle and enters ACQUIRE
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (fault !== (k == 16) || locked !== 1'b0) begin
        errors++;
        $display("FAIL no_lock_timing edge %0d: fault=%b locked=%b, want %b 0",
                 k, fault, locked, (k == 16));
      end
    end
    exp_cnt++;
    checks++;
    if (fault_code !== 3'd2 || fault_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL no_lock_code: code=%0d count=%0d, want 2 %0d", fault_code, fault_count, exp_cnt);
    end
  endtask

  task automatic test_stall();
    reset = 1'b0;
    f_pair = 1'b0;
    f_zero = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    exp_cnt = 0;
    for (int k = 1; k <= 16; k++) begin
      tick();
      checks++;
      if (fault !== (k == 16) || locked !== 1'b0) begin
        errors++;
        $display("FAIL stall_timing edge %0d: fault=%b locked=%b, want %b 0",
                 k, fault, locked, (k == 16));
      end
    end
    exp_cnt++;
    checks++;
    if (fault_code !== 3'd1 || fault_count !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL stall_code: code=%0d count=%0d, want 1 %0d", fault_code, fault_count, exp_cnt);
    end
  endtask

  task automatic test_saturate();
    bit seen;
    @(negedge clock);
    f_zero = 1'b0;
    f_pair = 1'b1;
    for (int n = 0; n < 256; n++) begin
      @(negedge clock);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      seen = 1'b0;
      for (int t = 0; t < 40 && !seen; t++) begin
        tick();
        seen = fault;
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL saturate_timeout iter %0d: fault=%b, want 1 within 40 edges", n, fault);
        break;
      end
      if (exp_cnt < 255) exp_cnt++;
      checks++;
      if (fault_count !== 8'(exp_cnt)) begin
        errors++;
        $display("FAIL saturate_count iter %0d: count=%0d, want %0d", n, fault_count, exp_cnt);
      end
    end
  endtask

  task automatic test_reset_mid_locked();
    @(negedge clock);
    f_pair = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (9) tick();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_lock: locked=%b, want 1", locked);
    end
    #2;
    reset = 1'b0;
    #1;  // still before the next clock edge
    checks++;
    if ({locked, fault, fault_code, fault_count} !== 13'd0) begin
      errors++;
      $display("FAIL async_reset: locked=%b fault=%b code=%0d count=%0d, want all 0",
               locked, fault, fault_code, fault_count);
    end
    tick();
    reset = 1'b1;
    exp_cnt = 0;
    relock_from_reset("relock_after_reset");
  endtask

  initial begin
    test_reset();
    test_lock();
    test_pair_fault();
    test_clear_relock();
    test_missed_toggle();
    test_no_lock();
    test_stall();
    test_saturate();
    test_reset_mid_locked();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clock_phase_monitor.md
Name: clock_phase_monitor

Overview:
Checks the four derived clocks produced by the processor's clock divider (processor, imem, dmem, regfile) against the master clock that generates them. Samples each derived clock as data on the master posedge and checks two things: every derived clock toggles once per master cycle, and the complementary pairs (processor/dmem, imem/regfile) stay inverted. Reports lock, a sticky fault with a code, and a fault counter to the debug/status logic.

Parameters:
LOCK_CYCLES, 8, consecutive good samples required in ACQUIRE before asserting locked (>=1)
TIMEOUT, 64, master cycles allowed in IDLE (no toggle) or ACQUIRE (no lock) before faulting (>=2)

Ports:
clock  input  1  master clock; the same clock that feeds the divider; all logic on posedge
reset  input  1  asynchronous, active-low reset (asserted when 0)
processor_clock  input  1  derived clock under test
imem_clock  input  1  derived clock under test
dmem_clock  input  1  derived clock under test
regfile_clock  input  1  derived clock under test
clear  input  1  single-cycle pulse; exits FAULT; ignored in other states
locked  output  1  1 while in LOCKED
fault  output  1  1 while in FAULT
fault_code  output  3  cause of the current/last fault; 0 none, 1 STALL, 2 NO_LOCK, 3 PAIR, 4 MISSED_TOGGLE
fault_count  output  8  number of FAULT entries, saturating at 255

Behaviour:
- Reset (reset=0, asynchronous) sets: state=IDLE, locked=0, fault=0, fault_code=0, fault_count=0, counters=0, sample registers=0, prev_valid=0.
- Sampling: each posedge, s_cur <= {processor,imem,dmem,regfile}, s_prev <= s_cur, prev_valid <= 1 (from the second edge after reset release).
- toggle_ok = prev_valid && (s_cur ^ s_prev)==4'b1111. any_toggle = prev_valid && (s_cur ^ s_prev)!=0.
- pair_ok = (s_cur.processor ^ s_cur.dmem) && (s_cur.imem ^ s_cur.regfile).
- Latency: a violation in levels captured at edge N is evaluated combinationally and changes state/outputs at edge N+1.
- FSM, evaluated each posedge:
  IDLE: any_toggle -> ACQUIRE, good_cnt=0, wait_cnt=0. Otherwise wait_cnt++. When wait_cnt==TIMEOUT-1 and no toggle -> FAULT, code 1.
  ACQUIRE: toggle_ok&&pair_ok -> good_cnt++. On the LOCK_CYCLES-th consecutive good sample -> LOCKED. Any bad sample -> good_cnt=0, stay; no fault. wait_cnt++ every cycle. When wait_cnt==TIMEOUT-1 without lock -> FAULT, code 2. Lock wins if both happen in the same cycle.
  LOCKED: !pair_ok -> FAULT, code 3. Else !toggle_ok -> FAULT, code 4. PAIR has priority over MISSED_TOGGLE.
  FAULT: sticky. fault_code holds. clear=1 -> IDLE, counters=0, fault_code=0.
- fault_count increments on every transition into FAULT and saturates at 255. clear does not reset it; only reset does.
- locked and fault are registered state decodes and are never both 1.
- Counters are sized $clog2(TIMEOUT) and $clog2(LOCK_CYCLES+1) bits. Comparisons must not wrap.
- Reset asserted mid-operation forces all reset values immediately, with no clock needed. Release is synchronous to the next posedge.

Decomposition:
- Package clock_monitor_pkg: state enum {IDLE, ACQUIRE, LOCKED, FAULT}; fault code constants FC_NONE=0, FC_STALL=1, FC_NO_LOCK=2, FC_PAIR=3, FC_MISSED_TOGGLE=4; bit index constants for the 4-bit sample vector.
- One sub-module, clock_phase_sampler: owns s_cur, s_prev and prev_valid, and outputs toggle_ok, any_toggle and pair_ok. The top level holds the FSM, counters and outputs.

Test Plan:
1. Release reset; drive the four inputs from a behavioural model of the divider (also reset by the active-low reset); LOCK_CYCLES=8 -> IDLE exits on the first detected toggle, locked=1 exactly 9 edges later, fault stays 0.
2. Hold all four inputs at 0 after reset, TIMEOUT=16 -> fault=1, fault_code=1, fault_count=1 on the edge where wait_cnt reaches 15; locked never rises.
3. After lock, force dmem_clock equal to processor_clock for one master cycle -> locked=0, fault=1, fault_code=3 one edge after that sample; fault stays asserted after the force is removed.
4. After lock, freeze imem_clock and regfile_clock (still complementary) for one cycle -> fault_code=4 (not 3); fault_count increments by 1.
5. In FAULT, pulse clear while the inputs are healthy -> IDLE next edge, fault=0, fault_code=0, re-lock; fault_count is retained. Induce 256 faults -> fault_count holds at 255.
6. Pull reset low mid-LOCKED between clock edges -> locked, fault, fault_code and fault_count go to 0 with no clock edge; after release, the re-lock timing matches scenario 1.
